// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported unified instruction/data Memory between the
// instruction-fetch master (port I, read-only) and the load/store master
// (port D, read/write).  Exactly one access is in flight at a time:
//
//   IDLE  -> arbitrate, latch owner/address/write data/direction
//   ISSUE -> mem_addr/mem_wdata/mem_read|mem_write presented to Memory
//   RESP  -> Memory output captured into the owner's rdata register,
//            owner's valid pulses in the following cycle
//
// A continuously requesting master therefore completes one access every
// three cycles.  Addresses are passed through untranslated.
//
// Configuration macro: ARB_ROUND_ROBIN_EN
//   undefined : fixed priority D > I; after STARVE_MAX consecutive D grants
//               with I waiting, I is granted next.
//   defined   : starvation counter removed; a 1-bit pointer gives priority
//               to the master that was not granted last.
//
// Ports
//   clock, reset        system clock; synchronous active-high reset
//   i_req/i_addr        fetch request (held until i_valid) and byte address
//   i_rdata/i_valid     fetch data and one-cycle completion pulse
//   d_req/d_we/d_addr   data request, 1=store 0=load, byte address
//   d_wdata             store data
//   d_rdata/d_valid     load data (unchanged by stores), completion pulse
//   mem_addr/mem_wdata  to Memory address / write data
//   mem_write/mem_read  to Memory strobes, never high together
//   mem_rdata           from Memory, registered, valid one edge after mem_read
//   busy                high whenever the sequencer is not IDLE
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    output logic          i_valid,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_valid,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_write,
    output logic          mem_read,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t state_r;
    state_t state_nxt_s;

    logic owner_i_r;        // 1: current access belongs to I, 0: to D
    logic we_r;             // current access is a store
    logic grant_i_s;        // arbitration result, meaningful in IDLE with a request
    logic start_s;          // an access is accepted at this edge
    logic mem_read_nxt_s;
    logic mem_write_nxt_s;
    logic i_valid_nxt_s;
    logic d_valid_nxt_s;

`ifdef ARB_ROUND_ROBIN_EN
    logic rr_ptr_r;         // 1: I has priority on a collision, 0: D has
`else
    localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    logic [CW-1:0] starve_cnt_r;
    logic [CW-1:0] starve_cnt_nxt_s;
`endif

    // Arbitration between the two masters; only a collision needs a rule.
    always_comb begin
        grant_i_s = 1'b0;
        if (i_req && d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            grant_i_s = rr_ptr_r;
`else
            grant_i_s = (starve_cnt_r == CW'(STARVE_MAX));
`endif
        end else begin
            grant_i_s = i_req;
        end
    end

    // Next-state logic and next values of the registered Memory/valid outputs.
    always_comb begin
        state_nxt_s     = state_r;
        start_s         = 1'b0;
        mem_read_nxt_s  = 1'b0;
        mem_write_nxt_s = 1'b0;
        i_valid_nxt_s   = 1'b0;
        d_valid_nxt_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (i_req || d_req) begin
                    state_nxt_s     = ST_ISSUE;
                    start_s         = 1'b1;
                    // Fetches are always reads; a D access follows d_we.
                    mem_read_nxt_s  = grant_i_s | ~d_we;
                    mem_write_nxt_s = ~grant_i_s & d_we;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_nxt_s = ST_RESP;
            end
            ST_RESP: begin
                state_nxt_s   = ST_IDLE;
                i_valid_nxt_s = owner_i_r;
                d_valid_nxt_s = ~owner_i_r;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

`ifndef ARB_ROUND_ROBIN_EN
    // Starvation counter: counts D grants that leave I waiting, saturating.
    always_comb begin
        starve_cnt_nxt_s = starve_cnt_r;
        if (start_s && grant_i_s) begin
            starve_cnt_nxt_s = {CW{1'b0}};
        end else if (start_s && i_req && (starve_cnt_r != CW'(STARVE_MAX))) begin
            starve_cnt_nxt_s = starve_cnt_r + CW'(1);
        end else begin
            starve_cnt_nxt_s = starve_cnt_r;
        end
    end
`endif

    // Sequencer state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Arbitration history: starvation count or round-robin pointer.
    always_ff @(posedge clock) begin
        if (reset) begin
`ifdef ARB_ROUND_ROBIN_EN
            rr_ptr_r <= 1'b1;
`else
            starve_cnt_r <= {CW{1'b0}};
`endif
        end else begin
`ifdef ARB_ROUND_ROBIN_EN
            // Priority moves to whichever master did not just win.
            if (start_s) begin
                rr_ptr_r <= ~grant_i_s;
            end
`else
            starve_cnt_r <= starve_cnt_nxt_s;
`endif
        end
    end

    // Latched access, Memory strobes, response capture and completion pulses.
    always_ff @(posedge clock) begin
        if (reset) begin
            owner_i_r <= 1'b0;
            we_r      <= 1'b0;
            mem_addr  <= {AW{1'b0}};
            mem_wdata <= {DW{1'b0}};
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            i_valid   <= 1'b0;
            d_valid   <= 1'b0;
            i_rdata   <= {DW{1'b0}};
            d_rdata   <= {DW{1'b0}};
            busy      <= 1'b0;
        end else begin
            mem_read  <= mem_read_nxt_s;
            mem_write <= mem_write_nxt_s;
            i_valid   <= i_valid_nxt_s;
            d_valid   <= d_valid_nxt_s;
            busy      <= (state_nxt_s != ST_IDLE);
            if (start_s) begin
                owner_i_r <= grant_i_s;
                we_r      <= ~grant_i_s & d_we;
                mem_addr  <= grant_i_s ? i_addr : d_addr;
                mem_wdata <= grant_i_s ? {DW{1'b0}} : d_wdata;
            end
            if ((state_r == ST_RESP) && owner_i_r) begin
                i_rdata <= mem_rdata;
            end
            // Stores leave d_rdata untouched.
            if ((state_r == ST_RESP) && !owner_i_r && !we_r) begin
                d_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed scenarios (reset, fetch, store/load, collision, starvation, reset
// during ISSUE) followed by a randomized phase.  A transaction-level model
// predicts every cycle's outputs from the arbitration rules: an access
// granted at edge g shows its strobe after g, the sequencer is in RESP after
// g+1, valid/rdata appear after g+2 and the next grant may happen at g+3.
// A small Memory model answers mem_read/mem_write; unwritten words hold
// addr ^ 0x1234_567C (so address 4 holds 0x1234_5678).
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int STARVE = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = 32'h0;
    logic [31:0] i_rdata;
    logic        i_valid;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = 32'h0;
    logic [31:0] d_wdata = 32'h0;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_rdata;
    logic        busy;

    mem_port_arbiter #(.AW(32), .DW(32), .STARVE_MAX(STARVE)) dut (
        .clock(clock), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_valid(i_valid),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_valid(d_valid),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
        .mem_read(mem_read), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return a ^ 32'h1234_567C;
    endfunction

    // Memory: addresses used live in 0x0000-0x003C and 0x2000-0x203C.
    logic [31:0] env_mem [0:31];
    bit          env_wr  [0:31];
    always @(posedge clock) begin
        if (mem_write) begin
            env_mem[{mem_addr[13], mem_addr[5:2]}] <= mem_wdata;
            env_wr[{mem_addr[13], mem_addr[5:2]}]  <= 1'b1;
        end
        if (mem_read) begin
            mem_rdata <= env_wr[{mem_addr[13], mem_addr[5:2]}] ?
                         env_mem[{mem_addr[13], mem_addr[5:2]}] : dflt(mem_addr);
        end
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model state
    logic [31:0] ref_mem [logic [31:0]];
    bit          has_txn = 1'b0;
    int          g = 0;
    int          next_free = 0;
    int          starve = 0;
    bit          rr_i = 1'b1;
    bit          t_own_i, t_we, win_i;
    logic [31:0] t_addr, t_wdata, t_data;
    bit          e_mr, e_mw, e_iv, e_dv, e_busy, chk_addr;
    logic [31:0] e_addr = 32'h0, e_wdata = 32'h0, e_ird = 32'h0, e_drd = 32'h0;

    // Requester behaviour and observation log (1 = I completed, 0 = D)
    bit auto_mode = 1'b0;
    bit d_hold = 1'b0;
    int order[$];
    int nd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    function automatic logic [31:0] raddr();
        logic [31:0] a;
        a = ($urandom_range(0, 1) == 1) ? 32'h2000 : 32'h0;
        a = a | (32'($urandom_range(0, 15)) << 2);
        return a;
    endfunction

    task model_edge();
        e_mr = 1'b0; e_mw = 1'b0; e_iv = 1'b0; e_dv = 1'b0; e_busy = 1'b0; chk_addr = 1'b0;
        if (reset) begin
            has_txn = 1'b0; next_free = cyc + 1; starve = 0; rr_i = 1'b1;
            e_ird = 32'h0; e_drd = 32'h0; e_addr = 32'h0; e_wdata = 32'h0; chk_addr = 1'b1;
        end else begin
            if (has_txn && cyc == g + 1) e_busy = 1'b1;
            if (has_txn && cyc == g + 2) begin
                has_txn = 1'b0;
                if (t_own_i) begin e_iv = 1'b1; e_ird = t_data; end
                else begin e_dv = 1'b1; if (!t_we) e_drd = t_data; end
            end
            if (cyc >= next_free && (i_req || d_req)) begin
`ifdef ARB_ROUND_ROBIN_EN
                win_i = (i_req && d_req) ? rr_i : i_req;
                rr_i = !win_i;
`else
                win_i = (i_req && d_req) ? (starve == STARVE) : i_req;
                if (win_i) starve = 0;
                else if (i_req && starve < STARVE) starve = starve + 1;
`endif
                has_txn = 1'b1; g = cyc; next_free = cyc + 3;
                t_own_i = win_i;
                t_we    = !win_i && d_we;
                t_addr  = win_i ? i_addr : d_addr;
                t_wdata = d_wdata;
                if (t_we) begin ref_mem[t_addr] = t_wdata; t_data = 32'h0; end
                else t_data = ref_rd(t_addr);
                e_mr = !t_we; e_mw = t_we; e_addr = t_addr; e_wdata = t_wdata;
                chk_addr = 1'b1; e_busy = 1'b1;
            end
        end
    endtask

    task check_outputs();
        check("mem_read",  {31'b0, mem_read},  {31'b0, e_mr});
        check("mem_write", {31'b0, mem_write}, {31'b0, e_mw});
        check("rd_wr_excl", {31'b0, mem_read & mem_write}, 32'h0);
        check("i_valid",   {31'b0, i_valid},   {31'b0, e_iv});
        check("d_valid",   {31'b0, d_valid},   {31'b0, e_dv});
        check("busy",      {31'b0, busy},      {31'b0, e_busy});
        check("i_rdata",   i_rdata, e_ird);
        check("d_rdata",   d_rdata, e_drd);
        if (chk_addr) check("mem_addr", mem_addr, e_addr);
        if (e_mw) check("mem_wdata", mem_wdata, e_wdata);
        if (i_valid) order.push_back(1);
        if (d_valid) order.push_back(0);
    endtask

    task requester_update();
        if (e_iv) i_req = 1'b0;
        if (e_dv) d_req = d_hold;
        if (auto_mode) begin
            if (!i_req && $urandom_range(0, 2) == 0) begin
                i_req = 1'b1; i_addr = raddr();
            end
            if (!d_req && $urandom_range(0, 2) == 0) begin
                d_req = 1'b1; d_we = 1'($urandom_range(0, 1));
                d_addr = raddr(); d_wdata = $urandom;
            end
        end
    endtask

    task step();
        @(posedge clock);
        cyc++;
        model_edge();
        #1;
        check_outputs();
        requester_update();
    endtask

    initial begin
        // 1: reset held two cycles with both requests high
        reset = 1'b1; i_req = 1'b1; d_req = 1'b1; i_addr = 32'h4; d_addr = 32'h8;
        step(); step();
        check("reset_busy", {31'b0, busy}, 32'h0);
        reset = 1'b0; i_req = 1'b0; d_req = 1'b0;
        step();

        // 2: fetch from address 4
        order.delete();
        i_req = 1'b1; i_addr = 32'h0000_0004;
        repeat (4) step();
        check("fetch_data", i_rdata, 32'h1234_5678);
        check("fetch_count", 32'(order.size()), 32'd1);

        // 3: store then load at 0x2000
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF;
        repeat (4) step();
        d_req = 1'b1; d_we = 1'b0;
        repeat (4) step();
        check("load_after_store", d_rdata, 32'hDEAD_BEEF);

        // 4: collision, both requests raised together
        order.delete();
        i_req = 1'b1; i_addr = 32'h10;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000;
        repeat (8) step();
        check("collide_count", 32'(order.size()), 32'd2);
        if (order.size() == 2) begin
`ifdef ARB_ROUND_ROBIN_EN
            check("collide_first", 32'(order[0]), 32'd1);
`else
            check("collide_first", 32'(order[0]), 32'd0);
`endif
        end

        // 5: starvation, D requests back to back while I waits
        order.delete();
        d_hold = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2004;
        i_req = 1'b1; i_addr = 32'h8;
        repeat (20) step();
        d_hold = 1'b0;
        repeat (6) step();
        nd = 0;
        foreach (order[k]) begin
            if (order[k] == 1) break;
            nd++;
        end
`ifdef ARB_ROUND_ROBIN_EN
        check("starve_d_before_i", 32'(nd), 32'd0);
`else
        check("starve_d_before_i", 32'(nd), 32'(STARVE));
`endif

        // 6: reset while a load is in ISSUE
        order.delete();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (5) step();
        check("post_reset_load", d_rdata, 32'hDEAD_BEEF);
        check("post_reset_count", 32'(order.size()), 32'd1);

        // Randomized traffic, then drain
        auto_mode = 1'b1;
        repeat (600) step();
        auto_mode = 1'b0;
        repeat (8) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
